// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters with one-cycle look-ahead, frame counter,
// and active-low syncs delayed to line up with a registered RGB stage.
module vga_timing #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  position_x,
    output logic [9:0]  position_x_NEXT,
    output logic [8:0]  position_y,
    output logic [8:0]  position_y_NEXT,
    output logic        visible,
    output logic        visible_NEXT,
    output logic [31:0] frame,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        blank
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
    localparam logic [9:0] HVis       = 10'(H_VISIBLE);
    localparam logic [9:0] VVis       = 10'(V_VISIBLE);
    localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Pipe word layout: {hsync, vsync, blank}; reset value matches position (0,0).
    localparam logic [2:0] PipeReset = 3'b110;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [31:0] frame_q, frame_d;
    logic        frame_start_q;
    logic        h_wrap, f_wrap;
    logic        hsync0_d, vsync0_d, blank0_d;
    logic [2:0]  pipe_q [SYNC_DELAY + 1];

    always_comb begin
        h_wrap  = (h_cnt_q == HLast);
        f_wrap  = h_wrap && (v_cnt_q == VLast);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
        end
        frame_d = f_wrap ? frame_q + 32'd1 : frame_q;
    end

    // Stage 0 is evaluated on the next position so that, once registered, it lines up
    // with position_*.
    always_comb begin
        hsync0_d = !((h_cnt_d >= HSyncStart) && (h_cnt_d < HSyncEnd));
        vsync0_d = !((v_cnt_d >= VSyncStart) && (v_cnt_d < VSyncEnd));
        blank0_d = !((h_cnt_d < HVis) && (v_cnt_d < VVis));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            frame_q       <= 32'd0;
            frame_start_q <= 1'b1;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_q       <= frame_d;
            frame_start_q <= (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(SYNC_DELAY); i++) begin
                pipe_q[i] <= PipeReset;
            end
        end else begin
            pipe_q[0] <= {hsync0_d, vsync0_d, blank0_d};
            for (int i = 1; i <= int'(SYNC_DELAY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        position_x      = h_cnt_q;
        position_x_NEXT = h_cnt_d;
        position_y      = v_cnt_q[8:0];
        position_y_NEXT = v_cnt_d[8:0];
        visible         = (h_cnt_q < HVis) && (v_cnt_q < VVis);
        visible_NEXT    = (h_cnt_d < HVis) && (v_cnt_d < VVis);
        frame           = frame_q;
        frame_start     = frame_start_q;
        {hsync, vsync, blank} = pipe_q[SYNC_DELAY];
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for horizontal checks and a narrow-line instance
// (default vertical timing, SYNC_DELAY=2) so whole frames fit in a short run.
module tb_vga_timing;

    typedef struct {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int d;
    } timing_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  xn;
        logic [8:0]  y;
        logic [8:0]  yn;
        logic        vis;
        logic        visn;
        logic [31:0] fr;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        bl;
    } exp_t;

    localparam timing_t PA = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    localparam timing_t PB = '{8, 2, 4, 2, 480, 10, 2, 33, 2};

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_a, n_b;

    logic [9:0]  px_a, pxn_a, px_b, pxn_b;
    logic [8:0]  py_a, pyn_a, py_b, pyn_b;
    logic        vis_a, visn_a, fs_a, hs_a, vs_a, bl_a;
    logic        vis_b, visn_b, fs_b, hs_b, vs_b, bl_b;
    logic [31:0] fr_a, fr_b;
    exp_t        act_a, act_b;

    always #5 clk = ~clk;

    vga_timing u_dut_a (
        .clk(clk), .rst_n(rst_n_a),
        .position_x(px_a), .position_x_NEXT(pxn_a),
        .position_y(py_a), .position_y_NEXT(pyn_a),
        .visible(vis_a), .visible_NEXT(visn_a),
        .frame(fr_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a), .blank(bl_a)
    );

    vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .SYNC_DELAY(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .position_x(px_b), .position_x_NEXT(pxn_b),
        .position_y(py_b), .position_y_NEXT(pyn_b),
        .visible(vis_b), .visible_NEXT(visn_b),
        .frame(fr_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b), .blank(bl_b)
    );

    assign act_a = '{x:px_a, xn:pxn_a, y:py_a, yn:pyn_a, vis:vis_a, visn:visn_a,
                     fr:fr_a, fs:fs_a, hs:hs_a, vs:vs_a, bl:bl_a};
    assign act_b = '{x:px_b, xn:pxn_b, y:py_b, yn:pyn_b, vis:vis_b, visn:visn_b,
                     fr:fr_b, fs:fs_b, hs:hs_b, vs:vs_b, bl:bl_b};

    // Model time base: clock edges seen since the last reset release.
    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) n_a <= 0;
        else          n_a <= n_a + 1;
    end

    always @(posedge clk or negedge rst_n_b) begin
        if (!rst_n_b) n_b <= 0;
        else          n_b <= n_b + 1;
    end

    // Everything follows from the raster position at edge count n; syncs look back d edges.
    function automatic exp_t model(timing_t p, int n);
        int   ht, vt, line, linen, m, xm, lm;
        exp_t e;
        ht     = p.hv + p.hf + p.hs + p.hb;
        vt     = p.vv + p.vf + p.vs + p.vb;
        line   = (n / ht) % vt;
        linen  = ((n + 1) / ht) % vt;
        e.x    = 10'(n % ht);
        e.xn   = 10'((n + 1) % ht);
        e.y    = 9'(line);
        e.yn   = 9'(linen);
        e.vis  = ((n % ht) < p.hv) && (line < p.vv);
        e.visn = (((n + 1) % ht) < p.hv) && (linen < p.vv);
        e.fr   = 32'(n / (ht * vt));
        e.fs   = (n % (ht * vt)) == 0;
        m      = (n >= p.d) ? n - p.d : 0;
        xm     = m % ht;
        lm     = (m / ht) % vt;
        e.hs   = !((xm >= p.hv + p.hf) && (xm < p.hv + p.hf + p.hs));
        e.vs   = !((lm >= p.vv + p.vf) && (lm < p.vv + p.vf + p.vs));
        e.bl   = !((xm < p.hv) && (lm < p.vv));
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, exp_t a, exp_t e);
        chk({tag, ".x"},     32'(a.x),    32'(e.x));
        chk({tag, ".x_nxt"}, 32'(a.xn),   32'(e.xn));
        chk({tag, ".y"},     32'(a.y),    32'(e.y));
        chk({tag, ".y_nxt"}, 32'(a.yn),   32'(e.yn));
        chk({tag, ".vis"},   32'(a.vis),  32'(e.vis));
        chk({tag, ".visn"},  32'(a.visn), 32'(e.visn));
        chk({tag, ".frame"}, a.fr,        e.fr);
        chk({tag, ".fs"},    32'(a.fs),   32'(e.fs));
        chk({tag, ".hsync"}, 32'(a.hs),   32'(e.hs));
        chk({tag, ".vsync"}, 32'(a.vs),   32'(e.vs));
        chk({tag, ".blank"}, 32'(a.bl),   32'(e.bl));
    endtask

    always @(negedge clk) begin
        cmp("a", act_a, model(PA, n_a));
        cmp("b", act_b, model(PB, n_b));
    end

    int hs_low_cnt = 0;
    int hs_first = -1;
    int hs_last = -1;
    int fs_cnt = 0;
    int vs_low_cnt = 0;
    int iter = 0;

    initial begin
        repeat (5) @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        #1;
        chk("rel.x", 32'(px_a), 0);
        chk("rel.y", 32'(py_a), 0);
        chk("rel.x_nxt", 32'(pxn_a), 1);
        chk("rel.frame", fr_a, 0);
        chk("rel.hsync", 32'(hs_a), 1);
        chk("rel.vsync", 32'(vs_a), 1);
        chk("rel.blank", 32'(bl_a), 0);

        while (n_b != 28410) begin
            @(posedge clk);
            #1;
            iter++;
            if (iter > 40000) begin
                chk("run.timeout", 32'(n_b), 28410);
                break;
            end
            if (n_a == 1) chk("a.first_x", 32'(px_a), 1);
            if (n_a == 799) begin
                chk("a.wrap_xn", 32'(pxn_a), 0);
                chk("a.wrap_yn", 32'(pyn_a), 1);
            end
            if (n_a == 800) begin
                chk("a.line_x", 32'(px_a), 0);
                chk("a.line_y", 32'(py_a), 1);
                chk("a.line_frame", fr_a, 0);
            end
            if (n_a >= 800 && n_a < 1600 && !hs_a) begin
                hs_low_cnt++;
                if (hs_first < 0) hs_first = int'(px_a);
                hs_last = int'(px_a);
            end
            if (n_a == 1600) begin
                chk("a.hs_low_cnt", hs_low_cnt, 96);
                chk("a.hs_first_x", hs_first, 657);
                chk("a.hs_last_x", hs_last, 752);
            end
            if (n_b == 7671) chk("b.vis_7_479", 32'(vis_b), 1);
            if (n_b == 7672) chk("b.vis_8_479", 32'(vis_b), 0);
            if (n_b == 7680) chk("b.vis_0_480", 32'(vis_b), 0);
            if (n_b == 8192) begin
                chk("b.y_alias512", 32'(py_b), 0);
                chk("b.vis_512", 32'(vis_b), 0);
            end
            if (n_b == 8399) chk("b.frame_pre", fr_b, 0);
            if (n_b == 8400) begin
                chk("b.frame_post", fr_b, 1);
                chk("b.fwrap_x", 32'(px_b), 0);
                chk("b.fwrap_y", 32'(py_b), 0);
            end
            if (n_b >= 1 && n_b <= 8400 && fs_b) fs_cnt++;
            if (n_b == 8401) chk("b.fs_cnt", fs_cnt, 1);
            if (n_b >= 8400 && n_b < 16800 && !vs_b) vs_low_cnt++;
            if (n_b == 16800) chk("b.vs_low_cnt", vs_low_cnt, 32);
        end

        // Mid-frame reset at (10,200) of frame 3.
        chk("mid.frame", fr_b, 3);
        chk("mid.x", 32'(px_b), 10);
        chk("mid.y", 32'(py_b), 200);
        rst_n_b = 1'b0;
        #1;
        chk("mid.rst_x", 32'(px_b), 0);
        chk("mid.rst_y", 32'(py_b), 0);
        chk("mid.rst_xn", 32'(pxn_b), 1);
        chk("mid.rst_frame", fr_b, 0);
        chk("mid.rst_fs", 32'(fs_b), 1);
        chk("mid.rst_hsync", 32'(hs_b), 1);
        chk("mid.rst_vsync", 32'(vs_b), 1);
        chk("mid.rst_blank", 32'(bl_b), 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid.after_frame", fr_b, 0);
        chk("mid.after_x", 32'(px_b), 4);
        chk("mid.after_y", 32'(py_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
